// File: rtl/intrarecon_luma4x4.sv
// intrarecon_luma4x4: H.264 4x4 luma intra prediction plus residual reconstruction.
// Define INTRARECON_CLIPSTAT_EN to build the saturating clipped-pixel counter.
module intrarecon_luma4x4 (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [15:0][7:0] res,
  input  logic [7:0][7:0]  toppixels,
  input  logic [4:0][7:0]  leftpixels,
  input  logic [31:0]      mbnumber_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] recon,
  output logic [31:0]      mbnumber_out,
  output logic [15:0]      clip_count
);
  typedef enum logic [1:0] {IDLE, PRED, RECON, OUT} state_t;
  state_t state, state_n;
  logic [2:0] mode_q;
  logic [15:0][7:0] res_q, pred_q, pred_c, recon_c;
  logic [7:0][7:0] top_q;
  logic [4:0][7:0] left_q;
  logic [15:0][7:0] nb;
  logic [15:0][9:0] sum_c;
  // Neighbours as one line L K J I M A..H, so every mode indexes a single array; top end padded with H.
  assign nb = {top_q[7], top_q[7], top_q[7], top_q, left_q[0], left_q[1], left_q[2], left_q[3], left_q[4]};
  function automatic logic [7:0] px(input int i);
    return nb[4'(i)];
  endfunction
  function automatic logic [7:0] f2(input logic [7:0] a, input logic [7:0] b);
    logic [9:0] s;
    s = {2'b0, a} + {2'b0, b} + 10'd1;
    return 8'(s >> 1);
  endfunction
  function automatic logic [7:0] f3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [9:0] s;
    s = {2'b0, a} + {1'b0, b, 1'b0} + {2'b0, c} + 10'd2;
    return 8'(s >> 2);
  endfunction
  always_comb begin
    pred_c = '0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        case (mode_q)
          3'd0: pred_c[4*y+x] = px(5 + x);
          3'd1: pred_c[4*y+x] = px(3 - y);
          3'd2: pred_c[4*y+x] = y[0] ? f3(px(5 + x + y/2), px(6 + x + y/2), px(7 + x + y/2))
                                     : f2(px(5 + x + y/2), px(6 + x + y/2));
          3'd3: pred_c[4*y+x] = (2*x - y < -1) ? f3(px(4 - y), px(5 - y), px(6 - y))
                              : !y[0] ? f2(px(4 + x - y/2), px(5 + x - y/2))
                              : f3(px(3 + x - y/2), px(4 + x - y/2), px(5 + x - y/2));
          3'd4: pred_c[4*y+x] = (x + 2*y > 5) ? px(0)
                              : (x + 2*y == 5) ? f3(px(1), px(0), px(0))
                              : !x[0] ? f2(px(3 - y - x/2), px(2 - y - x/2))
                              : f3(px(3 - y - x/2), px(2 - y - x/2), px(1 - y - x/2));
          3'd5: pred_c[4*y+x] = (2*y - x < -1) ? f3(px(4 + x), px(3 + x), px(2 + x))
                              : !x[0] ? f2(px(3 - y + x/2), px(4 - y + x/2))
                              : f3(px(3 - y + x/2), px(4 - y + x/2), px(5 - y + x/2));
          3'd6: pred_c[4*y+x] = (x == 3 && y == 3) ? f3(px(11), px(12), px(12))
                              : f3(px(5 + x + y), px(6 + x + y), px(7 + x + y));
          default: pred_c[4*y+x] = f3(px(3 + x - y), px(4 + x - y), px(5 + x - y));
        endcase
  end
  always_comb begin
    sum_c = '0;
    recon_c = '0;
    for (int i = 0; i < 16; i++) begin
      sum_c[i] = {2'b0, pred_q[i]} + {{2{res_q[i][7]}}, res_q[i]};
      recon_c[i] = sum_c[i][9] ? 8'd0 : sum_c[i][8] ? 8'd255 : sum_c[i][7:0];
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (enable)
      case (state)
        IDLE: state_n = in_valid ? PRED : IDLE;
        PRED: state_n = RECON;
        RECON: state_n = OUT;
        default: state_n = out_ready ? IDLE : OUT;
      endcase
  end
  assign in_ready = state == IDLE && enable;
  assign out_valid = state == OUT;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mode_q <= '0;
      res_q <= '0;
      top_q <= '0;
      left_q <= '0;
      mbnumber_out <= '0;
      pred_q <= '0;
      recon <= '0;
    end else if (enable) begin
      if (in_valid && in_ready) begin
        mode_q <= mode;
        res_q <= res;
        top_q <= toppixels;
        left_q <= leftpixels;
        mbnumber_out <= mbnumber_in;
      end
      if (state == PRED) pred_q <= pred_c;
      if (state == RECON) recon <= recon_c;
    end
`ifdef INTRARECON_CLIPSTAT_EN
  logic [4:0] n_clip;
  logic [16:0] cnt_sum;
  always_comb begin
    n_clip = '0;
    for (int i = 0; i < 16; i++) n_clip = n_clip + 5'(sum_c[i][9] | sum_c[i][8]);
  end
  assign cnt_sum = {1'b0, clip_count} + 17'(n_clip);
  always_ff @(posedge clk or negedge reset)
    if (!reset) clip_count <= '0;
    else if (enable && state == RECON) clip_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
`else
  assign clip_count = '0;
`endif
endmodule

// File: doc/intrarecon_luma4x4.md
INTRARECON_LUMA4X4 -- requirements
Module: intrarecon_luma4x4

Interface
REQ-001 SHALL have no parameters; block size is fixed at 4x4 luma, 8-bit samples.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  global hold; when low, the FSM and all registers hold their values.
REQ-005 in_valid  input  1  block descriptor valid.
REQ-006 in_ready  output  1  block accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 mode  input  3  luma 4x4 mode: 0 V, 1 H, 2 VL, 3 VR, 4 HU, 5 HD, 6 DDL, 7 DDR.
REQ-008 res  input  16x8 signed  residual; index 4*row+col.
REQ-009 toppixels  input  8x8  neighbours A..H at indices 0..7.
REQ-010 leftpixels  input  5x8  neighbours M, I, J, K, L at indices 0..4.
REQ-011 mbnumber_in  input  32  block number; passed through unchanged to the output.
REQ-012 out_valid  output  1  reconstructed block valid.
REQ-013 out_ready  input  1  downstream accepts the block.
REQ-014 recon  output  16x8 unsigned  reconstructed pixels; index 4*row+col.
REQ-015 mbnumber_out  output  32  captured mbnumber_in.
REQ-016 clip_count  output  16  clipped-pixel statistic; see Configuration.

Function
REQ-017 FSM SHALL have four states: IDLE, PRED, RECON, OUT.
REQ-018 in_ready SHALL equal (state==IDLE) AND enable.
REQ-019 On the in handshake, the block SHALL register mode, res, toppixels, leftpixels and mbnumber_in, then go to PRED.
REQ-020 PRED SHALL compute all 16 prediction samples for the captured mode and register them, then go to RECON.
- Equations: H.264 clause 8.3.1.2.
- Rounding: (a+2b+c+2)>>2 and (a+b+1)>>1.
- Intermediate sums: at least 10 bits wide.
REQ-021 RECON SHALL register recon[i] = clip(pred[i] + sign-extended res[i]) into the range 0..255, using 10-bit signed arithmetic, then go to OUT.
REQ-022 In OUT, out_valid SHALL be 1 and recon and mbnumber_out SHALL be stable until out_ready is high at a rising edge; after that edge the FSM SHALL go to IDLE.
REQ-023 Latency: handshake at edge k, out_valid high from edge k+2 when enable stays high; throughput is at most one block per 4 cycles.
REQ-024 In IDLE, out_valid SHALL be 0; recon SHALL hold its last value.
REQ-025 enable low SHALL stall any state, including OUT; out_valid SHALL keep its value while stalled.
REQ-026 in_valid SHALL be ignored in every state other than IDLE.

Reset
REQ-027 reset low SHALL asynchronously force:
- state to IDLE;
- out_valid, recon, mbnumber_out, clip_count and all internal registers to 0.
REQ-028 Reset asserted during PRED, RECON or OUT SHALL abandon the block; no partial output SHALL be produced.
REQ-029 in_ready SHALL be high in the first cycle after reset is released with enable high.

Configuration
REQ-030 Macro INTRARECON_CLIPSTAT_EN, when defined, SHALL enable the clip statistic.
- In RECON, clip_count SHALL add the number of pixels clipped in that block (either bound).
- The counter SHALL saturate at 0xFFFF.
REQ-031 Without INTRARECON_CLIPSTAT_EN, clip_count SHALL be tied to 0 and no counter logic SHALL be built; all other behaviour is identical.

Verification
REQ-032 Mode 0, A..D = 10,20,30,40, res all 0, handshake at edge k -> every row = 10,20,30,40; out_valid rises at edge k+2.
REQ-033 Mode 1, I..L = 100,110,120,130, res all +5 -> rows 105 / 115 / 125 / 135.
REQ-034 Clipping, mode 0:
- A..D = 250,3,3,3; res column 0 = +10, columns 1..3 = -10 -> column 0 = 255, others = 0.
- With INTRARECON_CLIPSTAT_EN, clip_count = 16.
REQ-035 Mode 6, A..H = 0,4,...,28, res 0 -> row0 = 4,8,12,16; recon[15] = 27.
REQ-036 out_ready low for 5 cycles in OUT, second in_valid held high -> recon stable, in_ready 0; the second block is accepted the cycle after the out handshake.
REQ-037 reset pulsed low during RECON -> out_valid 0 immediately; after release, in_ready = 1 and a new block completes normally.
